// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t : fetch sequencer FSM states
//   br_type_t     : redirect kind supplied by the execute stage
//   INSTR_BYTES   : size of one instruction word in bytes
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        BR_UNCOND = 2'd0,   // pc-relative, 26-bit word offset
        BR_COND   = 2'd1,   // pc-relative, 19-bit word offset
        BR_REG    = 2'd2    // absolute target from a register
    } br_type_t;

endpackage : cpu_pkg

// File: rtl/branch_target.sv
// -----------------------------------------------------------------------------
// branch_target
// Purely combinational redirect-target generator.
//   br_type : kind of redirect (see br_type_t)
//   br_pc   : PC of the redirecting instruction
//   br_imm  : signed word offset; only [18:0] matter for BR_COND
//   br_reg  : register target for BR_REG
//   target  : next fetch address, word aligned; additions wrap mod 2^ADDR_W
// -----------------------------------------------------------------------------
module branch_target
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  br_type_t          br_type,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [25:0]       br_imm,
    input  logic [ADDR_W-1:0] br_reg,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] off_uncond;
    logic [ADDR_W-1:0] off_cond;

    // Sign-extend the word offset and scale it to bytes in one concatenation.
    assign off_uncond = {{(ADDR_W-28){br_imm[25]}}, br_imm[25:0], 2'b00};
    assign off_cond   = {{(ADDR_W-21){br_imm[18]}}, br_imm[18:0], 2'b00};

    always_comb begin
        // NOTE: assigning a default before the case means no path leaves
        // target unassigned, so no latch is inferred.
        target = br_pc + off_uncond;
        case (br_type)
            BR_UNCOND: target = br_pc + off_uncond;
            BR_COND:   target = br_pc + off_cond;
            BR_REG:    target = {br_reg[ADDR_W-1:2], 2'b00};
            default:   target = br_pc + off_uncond;   // unused encoding
        endcase
    end

endmodule : branch_target

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter and drives the instruction-memory address.
//   clk          : clock, all state on the rising edge
//   reset        : asynchronous, active-low reset
//   stall        : hazard-unit hold, keep PC and re-present the fetch
//   br_taken     : execute-stage redirect request
//   br_type      : redirect kind (br_type_t)
//   br_pc        : PC of the redirecting instruction
//   br_imm       : word offset for pc-relative redirects
//   br_reg       : register target for BR_REG
//   pc           : current fetch address
//   pc_plus4     : pc + 4 (wraps)
//   if_valid     : the fetch at pc is valid this cycle
//   flush        : kill IF/ID contents (combinational)
//   redirect_cnt : taken redirects since reset, saturating
//   stall_cnt    : cycles spent in HOLD, saturating
// -----------------------------------------------------------------------------
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  br_type_t          br_type,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [25:0]       br_imm,
    input  logic [ADDR_W-1:0] br_reg,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              if_valid,
    output logic              flush,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [ADDR_W-1:0] target;
    logic              take_redirect;
    logic              in_hold;

    branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
        .br_type (br_type),
        .br_pc   (br_pc),
        .br_imm  (br_imm),
        .br_reg  (br_reg),
        .target  (target)
    );

    assign pc_plus4 = pc_q + ADDR_W'(INSTR_BYTES);

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid      = 1'b0;
        take_redirect = 1'b0;
        in_hold       = 1'b0;

        case (state_q)
            BOOT: begin
                // Memory has no outstanding read yet; redirects and holds
                // are meaningless until the first fetch is issued.
                state_d = RUN;
            end
            RUN: begin
                if_valid = 1'b1;
                if (br_taken) begin
                    take_redirect = 1'b1;
                end else if (stall) begin
                    state_d = HOLD;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                in_hold  = 1'b1;
                if (br_taken) begin
                    take_redirect = 1'b1;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                // Target read still in flight: stall is ignored, and pc is
                // held so RUN re-presents the target with if_valid=1.
                if (br_taken) begin
                    take_redirect = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        if (take_redirect) begin
            pc_d    = target;
            state_d = REDIRECT;
        end
    end

    assign flush = br_taken && (state_q != BOOT);

    // Saturating performance counters.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (take_redirect && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
        if (in_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every flop sampling the values from
    // before the edge, independent of statement order; the asynchronous reset
    // clears state without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign pc           = pc_q;
    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule : fetch_sequencer
